// File: rtl/fp16_pkg.sv
// Shared half-precision definitions: field widths, special encodings,
// divider state codes and the per-operand classification record.
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int BIAS   = 15;

    localparam logic [15:0] QNAN    = 16'h7E00;
    localparam logic [15:0] POS_INF = 16'h7C00;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_DIV  = 2'd1;
    localparam state_t ST_NORM = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    typedef struct packed {
        logic              zero;
        logic              sub;
        logic              inf;
        logic              nan;
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W:0]   sig;
    } fp_class_t;

    typedef struct packed {
        logic overflow;
        logic zero;
        logic nan;
        logic lost;
    } fp_flags_t;

endpackage

// File: rtl/fp16_classify.sv
// Decodes one fp16 operand into zero/subnormal/inf/nan flags plus the
// significand with its hidden bit; subnormals decode as zero.
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [15:0] op,
    output fp_class_t   cls
);

    logic [EXP_W-1:0]  e_s;
    logic [FRAC_W-1:0] f_s;

    assign e_s = op[14:10];
    assign f_s = op[9:0];

    // Field decode.
    always_comb begin
        cls.sign = op[15];
        cls.exp  = e_s;
        cls.zero = (e_s == 5'd0);
        cls.sub  = (e_s == 5'd0) && (f_s != 10'd0);
        cls.inf  = (e_s == 5'd31) && (f_s == 10'd0);
        cls.nan  = (e_s == 5'd31) && (f_s != 10'd0);
        if (e_s == 5'd0) begin
            cls.sig = 11'd0;
        end else begin
            cls.sig = {1'b1, f_s};
        end
    end

endmodule

// File: rtl/fp16_divider.sv
// Sequential fp16 divider: special operands resolve in one cycle, normal
// operands run a one-bit-per-cycle restoring division followed by a pack step.
module fp16_divider
    import fp16_pkg::*;
#(
    parameter int QBITS = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] num1,
    input  logic [15:0] num2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        overflow,
    output logic        zero,
    output logic        NaN,
    output logic        precisionLost
);

    fp_class_t c1_s, c2_s;

    fp16_classify u_cls1 (.op(num1), .cls(c1_s));
    fp16_classify u_cls2 (.op(num2), .cls(c2_s));

    state_t            state_q, state_d;
    logic [11:0]       rem_q, rem_d;
    logic [10:0]       div_q, div_d;
    logic [QBITS-1:0]  q_q, q_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [6:0]        exp_q, exp_d;
    logic              sign_q, sign_d;
    logic [15:0]       result_q, result_d;
    fp_flags_t         flags_q, flags_d;

    logic              ge_s;
    logic [10:0]       trial_s;
    logic              sgn_s;
    logic              lost_s;
    logic [6:0]        exp_adj_s;
    logic [9:0]        frac_s;

    // Next-state, datapath iteration and result packing.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        div_d     = div_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        exp_d     = exp_q;
        sign_d    = sign_q;
        result_d  = result_q;
        flags_d   = flags_q;
        sgn_s     = c1_s.sign ^ c2_s.sign;
        ge_s      = (rem_q >= {1'b0, div_q});
        // When ge_s holds the true difference is below the divisor, so 11 bits suffice.
        trial_s   = rem_q[10:0] - div_q;
        exp_adj_s = 7'd0;
        frac_s    = 10'd0;
        lost_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (c1_s.nan || c2_s.nan || (c1_s.zero && c2_s.zero) ||
                        (c1_s.inf && c2_s.inf)) begin
                        result_d = QNAN;
                        flags_d  = {1'b0, 1'b0, 1'b1, 1'b0};
                        state_d  = ST_DONE;
                    end else if (c2_s.zero) begin
                        result_d = {sgn_s, POS_INF[14:0]};
                        flags_d  = {1'b1, 1'b0, 1'b0, c1_s.sub | c2_s.sub};
                        state_d  = ST_DONE;
                    end else if (c1_s.inf) begin
                        result_d = {sgn_s, POS_INF[14:0]};
                        flags_d  = {1'b0, 1'b0, 1'b0, c1_s.sub | c2_s.sub};
                        state_d  = ST_DONE;
                    end else if (c1_s.zero || c2_s.inf) begin
                        result_d = {sgn_s, 15'd0};
                        flags_d  = {1'b0, 1'b1, 1'b0, c1_s.sub | c2_s.sub};
                        state_d  = ST_DONE;
                    end else begin
                        rem_d   = {1'b0, c1_s.sig};
                        div_d   = c2_s.sig;
                        q_d     = '0;
                        cnt_d   = 4'd0;
                        exp_d   = {2'b00, c1_s.exp} - {2'b00, c2_s.exp} + 7'(BIAS);
                        sign_d  = sgn_s;
                        state_d = ST_DIV;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIV: begin
                q_d = {q_q[QBITS-2:0], ge_s};
                if (ge_s) begin
                    rem_d = {trial_s, 1'b0};
                end else begin
                    rem_d = {rem_q[10:0], 1'b0};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(QBITS - 1)) begin
                    state_d = ST_NORM;
                end else begin
                    state_d = ST_DIV;
                end
            end
            ST_NORM: begin
                if (q_q[QBITS-1]) begin
                    exp_adj_s = exp_q;
                    frac_s    = q_q[QBITS-2 -: 10];
                    lost_s    = (|q_q[1:0]) | (rem_q != 12'd0);
                end else begin
                    exp_adj_s = exp_q - 7'd1;
                    frac_s    = q_q[QBITS-3 -: 10];
                    lost_s    = q_q[0] | (rem_q != 12'd0);
                end
                if ($signed(exp_adj_s) >= 7'sd31) begin
                    result_d = {sign_q, POS_INF[14:0]};
                    flags_d  = {1'b1, 1'b0, 1'b0, lost_s};
                end else if ($signed(exp_adj_s) <= 7'sd0) begin
                    result_d = {sign_q, 15'd0};
                    flags_d  = {1'b0, 1'b1, 1'b0, 1'b1};
                end else begin
                    result_d = {sign_q, exp_adj_s[4:0], frac_s};
                    flags_d  = {1'b0, 1'b0, 1'b0, lost_s};
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rem_q    <= 12'd0;
            div_q    <= 11'd0;
            q_q      <= '0;
            cnt_q    <= 4'd0;
            exp_q    <= 7'd0;
            sign_q   <= 1'b0;
            result_q <= 16'd0;
            flags_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign out_valid     = (state_q == ST_DONE);
    assign result        = result_q;
    assign overflow      = flags_q.overflow;
    assign zero          = flags_q.zero;
    assign NaN           = flags_q.nan;
    assign precisionLost = flags_q.lost;

endmodule
